// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side frame checker.
//   - FSM state encoding for frame_check
//   - parity-mode constants
//   - legal limits for DATA_WIDTH and STOP_MAX
//   - stop-count clamp helper
package uart_pkg;

  localparam int DATA_W_MIN   = 5;
  localparam int DATA_W_MAX   = 9;
  localparam int STOP_MIN     = 1;
  localparam int STOP_MAX_LIM = 3;

  // Wide enough to hold DATA_W_MAX-1 and STOP_MAX_LIM-1.
  localparam int BIT_CNT_W = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // A request of zero stop bits still checks one; requests above the
  // configured maximum are trimmed to it.
  function automatic logic [1:0] clamp_stop(input logic [1:0] req,
                                            input logic [1:0] max_stop);
    if (req == 2'd0)
      return 2'd1;
    else if (req > max_stop)
      return max_stop;
    else
      return req;
  endfunction

endpackage

// File: rtl/frame_check_if.sv
// Bit-stream and result bundle between the oversampling front end and
// frame_check.
//   frame_start  one-cycle start-edge pulse
//   bit_valid    strobe, sampled_bit holds the voted bit
//   sampled_bit  voted line value
//   frame_done   one-cycle pulse at frame end or abort
//   strt_err/par_err/stp_err  per-frame error flags
//   err_cnt      saturating count of frames with any error
interface frame_check_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 frame_start;
  logic                 bit_valid;
  logic                 sampled_bit;
  logic                 frame_done;
  logic                 strt_err;
  logic                 par_err;
  logic                 stp_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output frame_start, bit_valid, sampled_bit,
    input  frame_done, strt_err, par_err, stp_err, err_cnt
  );

  modport slave (
    input  frame_start, bit_valid, sampled_bit,
    output frame_done, strt_err, par_err, stp_err, err_cnt
  );
endinterface

// File: rtl/uart_bit_cnt.sv
// Loadable down-counter used to count data and stop bits.
//   clk, rst_n  clock, async active-low reset
//   load        load load_val (takes priority over dec)
//   load_val    value to load
//   dec         decrement by one
//   zero        count is currently zero
module uart_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/frame_check.sv
// UART receive frame checker: walks start/data/parity/stop bits on
// bit_valid strobes, flags start/parity/stop errors and counts bad frames.
//   CLK, RST      clock, async active-low reset
//   bus           frame_check_if slave (bit stream in, results out)
//   cfg_par_en    parity bit present
//   cfg_par_odd   1 = odd parity, 0 = even
//   cfg_stop_num  stop bits expected (clamped to 1..STOP_MAX)
//   err_clr       synchronous clear of err_cnt
module frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_MAX   = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  frame_check_if.slave bus,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic [1:0] cfg_stop_num,
  input  logic       err_clr
);

  state_e               state_q, state_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic [1:0]           stop_q, stop_d;
  logic                 acc_q, acc_d;
  logic                 done_q, done_d;
  logic                 strt_q, strt_d;
  logic                 par_q, par_d;
  logic                 stp_q, stp_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [BIT_CNT_W-1:0] cnt_val;

  uart_bit_cnt #(.W(BIT_CNT_W)) u_bit_cnt (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    stop_d    = stop_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    strt_d    = strt_q;
    par_d     = par_q;
    stp_d     = stp_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          par_en_d  = cfg_par_en;
          par_odd_d = cfg_par_odd;
          stop_d    = clamp_stop(cfg_stop_num, 2'(STOP_MAX));
          acc_d     = 1'b0;
          strt_d    = 1'b0;
          par_d     = 1'b0;
          stp_d     = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bus.bit_valid) begin
          if (bus.sampled_bit) begin
            // False start: abort without consuming the rest of the frame.
            strt_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = BIT_CNT_W'(DATA_WIDTH - 1);
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bus.bit_valid) begin
          acc_d = acc_q ^ bus.sampled_bit;
          if (cnt_zero) begin
            // Preload the stop count now so PARITY need not touch the counter.
            cnt_load = 1'b1;
            cnt_val  = BIT_CNT_W'(stop_q) - BIT_CNT_W'(1);
            state_d  = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bus.bit_valid) begin
          par_d   = acc_q ^ bus.sampled_bit ^ (par_odd_q == PAR_ODD);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bus.bit_valid) begin
          if (!bus.sampled_bit)
            stp_d = 1'b1;
          if (cnt_zero) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counted while frame_done is visible, using the flags shown with it;
  // a coincident clear wins.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)
      err_cnt_d = '0;
    else if (done_q && (strt_q || par_q || stp_q) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      par_en_q  <= 1'b0;
      par_odd_q <= PAR_EVEN;
      stop_q    <= 2'd1;
      acc_q     <= 1'b0;
      done_q    <= 1'b0;
      strt_q    <= 1'b0;
      par_q     <= 1'b0;
      stp_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop_q    <= stop_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      strt_q    <= strt_d;
      par_q     <= par_d;
      stp_q     <= stp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.frame_done = done_q;
  assign bus.strt_err   = strt_q;
  assign bus.par_err    = par_q;
  assign bus.stp_err    = stp_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule
